ramd32_fifo_ctrl: RTL
=====================

# ramd32_fifo_ctrl

Pointer and flag controller for a 32-deep first-word-fall-through FIFO built from a 32x1 dual-port distributed RAM (one RAM cell per data bit). It sits directly upstream of the RAM array and drives its write address, write enable and read address. It returns the RAM's asynchronous read output to the consumer with FULL/EMPTY/COUNT status. Data bits pass straight through: I fans out to the RAM, and RAM O returns as DOUT.

## Interface
- AF_TH, default 28: ALMOST_FULL asserts when COUNT >= AF_TH (legal 1..31)
- AE_TH, default 4: ALMOST_EMPTY asserts when COUNT <= AE_TH (legal 1..31)
- CLK  in  1  single clock, rising edge
- RST_N  in  1  synchronous, active-low reset, sampled on CLK rising edge
- PUSH  in  1  upstream write request
- POP  in  1  downstream read request
- WE  out  1  RAM write enable = PUSH & ~FULL (combinational)
- WADR  out  5  RAM write address = write pointer [4:0]
- RADR  out  5  RAM read address = read pointer [4:0]
- FULL  out  1  32 words stored
- EMPTY  out  1  0 words stored; DOUT invalid
- ALMOST_FULL  out  1  COUNT >= AF_TH
- ALMOST_EMPTY  out  1  COUNT <= AE_TH
- COUNT  out  6  occupancy 0..32
- OVF  out  1  sticky overflow flag (see Configuration)
- UDF  out  1  sticky underflow flag (see Configuration)

## Operation
- Write and read pointers are 6 bits: [4:0] is the RAM address and [5] is the wrap bit.
- EMPTY = (wptr == rptr). FULL = (wptr[4:0] == rptr[4:0]) & (wptr[5] != rptr[5]).
- Push accepted = PUSH & ~FULL. On acceptance, WE is high, the RAM captures I at WADR on the edge, and wptr increments mod 64.
- Pop accepted = POP & ~EMPTY. On acceptance, rptr increments mod 64.
- POP acknowledges the word currently presented at RADR. This is first-word-fall-through: the head word is readable whenever EMPTY is low.
- COUNT is a register: +1 on accepted push only, -1 on accepted pop only, unchanged when both or neither are accepted.
- Push and pop in the same cycle at 0 < COUNT < 32: both are accepted and COUNT holds.
- When FULL: push is rejected and pop is accepted, so COUNT goes 32 -> 31.
- When EMPTY: pop is rejected and push is accepted, so COUNT goes 0 -> 1.
- Wrap: the pointer goes 31 -> 32 (address 0, wrap bit 1) and 63 -> 0 with no discontinuity.
- RAM contents are never cleared. After reset, EMPTY masks stale data.

## Timing
- Reset values (RST_N low at an edge): wptr = rptr = 0, COUNT = 0, EMPTY = 1, FULL = 0, ALMOST_EMPTY = 1, ALMOST_FULL = 0, OVF = UDF = 0.
- WE during reset is forced to 0.
- Reset asserted mid-stream takes effect at that edge. A push in the same cycle is discarded and pointers return to 0.
- FULL, EMPTY, ALMOST_* and COUNT are derived only from registers, so they are glitch-free and update one edge after the causing event.
- Write-to-read latency: a word pushed at edge k makes EMPTY fall after edge k. DOUT is valid in cycle k+1 (zero extra latency, because the RAM read is asynchronous).
- WE, WADR and RADR are combinational from registers and PUSH only; there is no combinational path from POP.

## Configuration
- RAMD32_FIFO_ERR_EN defined:
  - OVF sets on PUSH & FULL.
  - UDF sets on POP & EMPTY.
  - Both are sticky until reset.
- Not defined: OVF and UDF are tied to 0 and the error logic is not synthesized.
- The port list is identical in both cases.

## Structure
- Shared package holds:
  - constants: DEPTH = 32, ADDR_W = 5, PTR_W = 6, CNT_W = 6
  - a pointer typedef (6-bit)
- Sub-module ramd32_fifo_ptr: a 6-bit pointer register with synchronous active-low reset and an increment enable. It is instantiated twice, once for the write pointer and once for the read pointer.
- Flag, count and error logic live in the top level.

## Test plan
- Reset: hold RST_N = 0 for 2 cycles with PUSH = 1. Required: WE = 0, EMPTY = 1, COUNT = 0, WADR = RADR = 0 throughout.
- Fill: 32 consecutive pushes of data 0..31. Required:
  - FULL rises after the 32nd edge, COUNT = 32
  - ALMOST_FULL rises after the 28th push
  - a 33rd push gives WE = 0, and OVF = 1 if RAMD32_FIFO_ERR_EN is defined
- Drain: 32 pops from full. Required:
  - DOUT sequence is 0..31
  - EMPTY rises after the last pop
  - a further POP leaves RADR unchanged, and UDF = 1 if RAMD32_FIFO_ERR_EN is defined
- Simultaneous push/pop:
  - at COUNT = 5, 10 cycles of PUSH = POP = 1: COUNT stays 5 and WADR and RADR both advance by 10
  - at COUNT = 32, PUSH = POP = 1: COUNT becomes 31 and WE = 0
- Wrap: 40 push/pop pairs starting from an offset of 30. Required: WADR goes 31 -> 0 with data integrity preserved, and FULL and EMPTY are never falsely asserted.
- Mid-stream reset: at COUNT = 17, pulse RST_N low for one edge. Required: COUNT = 0, EMPTY = 1, and the next push is written to WADR = 0.

Source files
------------

// File: rtl/ramd32_fifo_pkg.sv
// Shared constants and types for the 32-deep distributed-RAM FIFO controller.
package ramd32_fifo_pkg;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int CNT_W  = ADDR_W + 1;

    // [ADDR_W-1:0] addresses the RAM, the MSB is the wrap bit.
    typedef logic [PTR_W-1:0] ptr_t;

endpackage

// File: rtl/ramd32_fifo_ptr.sv
// Wrapping 6-bit FIFO pointer with synchronous active-low reset and increment enable.
module ramd32_fifo_ptr
    import ramd32_fifo_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    output ptr_t ptr
);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ramd32_fifo_ctrl.sv
// Pointer/flag controller for a 32-deep FWFT FIFO on 32x1 dual-port distributed RAM.
// Define RAMD32_FIFO_ERR_EN to build the sticky OVF/UDF error flags.
module ramd32_fifo_ctrl
    import ramd32_fifo_pkg::*;
#(
    parameter int AF_TH = 28,
    parameter int AE_TH = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              PUSH,
    input  logic              POP,
    output logic              WE,
    output logic [ADDR_W-1:0] WADR,
    output logic [ADDR_W-1:0] RADR,
    output logic              FULL,
    output logic              EMPTY,
    output logic              ALMOST_FULL,
    output logic              ALMOST_EMPTY,
    output logic [CNT_W-1:0]  COUNT,
    output logic              OVF,
    output logic              UDF
);

    localparam logic [CNT_W-1:0] AF_LVL = CNT_W'(AF_TH);
    localparam logic [CNT_W-1:0] AE_LVL = CNT_W'(AE_TH);

    ptr_t wptr;
    ptr_t rptr;
    logic push_acc;
    logic pop_acc;

    // NOTE: the RAM array is deliberately never cleared; resetting the pointers
    // makes EMPTY mask whatever stale words it still holds.
    ramd32_fifo_ptr u_wptr (
        .clk   (CLK),
        .rst_n (RST_N),
        .inc   (push_acc),
        .ptr   (wptr)
    );

    ramd32_fifo_ptr u_rptr (
        .clk   (CLK),
        .rst_n (RST_N),
        .inc   (pop_acc),
        .ptr   (rptr)
    );

    assign EMPTY = (wptr == rptr);
    assign FULL  = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) && (wptr[PTR_W-1] != rptr[PTR_W-1]);

    // RST_N gates the write strobe so a push issued during reset never reaches the RAM.
    assign push_acc = PUSH & ~FULL & RST_N;
    assign pop_acc  = POP & ~EMPTY;

    assign WE   = push_acc;
    assign WADR = wptr[ADDR_W-1:0];
    assign RADR = rptr[ADDR_W-1:0];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            COUNT <= '0;
        end else begin
            case ({push_acc, pop_acc})
                2'b10:   COUNT <= COUNT + 1'b1;
                2'b01:   COUNT <= COUNT - 1'b1;
                default: COUNT <= COUNT;
            endcase
        end
    end

    assign ALMOST_FULL  = (COUNT >= AF_LVL);
    assign ALMOST_EMPTY = (COUNT <= AE_LVL);

`ifdef RAMD32_FIFO_ERR_EN
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            OVF <= 1'b0;
            UDF <= 1'b0;
        end else begin
            if (PUSH && FULL)  OVF <= 1'b1;
            if (POP && EMPTY)  UDF <= 1'b1;
        end
    end
`else
    assign OVF = 1'b0;
    assign UDF = 1'b0;
`endif

endmodule
